// File: rtl/pwm_peripheral.sv
// pwm_peripheral
// Sixteen-pin PWM/static output driver. One shared PWM waveform is derived
// from the system clock through a prescaler and an 8-bit period counter.
// The duty value is shadowed at each period boundary, so an SPI write that
// lands mid-period never truncates or glitches the running period. Enables
// are applied directly, so an enable change reaches the pins one clock later.

module pwm_peripheral #(
  parameter int PRESCALE = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  // A prescaler of 1 still gets a one-bit counter that simply stays at zero,
  // which makes step permanently high.
  localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

  logic [PRE_W-1:0] pre_reg;
  logic [7:0]       cnt_reg;
  logic [7:0]       duty_sh_reg;
  logic [15:0]      out_reg;
  logic             period_start_reg;

  logic             step;
  logic             eop;
  logic             pwm;
  logic [15:0]      en_out;
  logic [15:0]      en_pwm;
  logic [15:0]      out_next;
  logic             period_start_next;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  // The counter advances once per prescaler wrap; the period ends on the
  // last prescaler tick of count 255.
  assign step = (pre_reg == PRE_LAST);
  assign eop  = step && (cnt_reg == 8'hFF);

  // 0xFF is special-cased so full duty never shows a one-step dip at 255.
  assign pwm = (duty_sh_reg == 8'hFF) || (cnt_reg < duty_sh_reg);

  // The first output cycle of a period is the one following pre == 0, cnt == 0.
  assign period_start_next = (pre_reg == '0) && (cnt_reg == 8'h00);

  // Prescaler: divides the system clock down to PWM counter steps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_reg <= '0;
    end else if (step) begin
      pre_reg <= '0;
    end else begin
      pre_reg <= pre_reg + PRE_ONE;
    end
  end

  // Period counter: free-running modulo 256 in prescaled steps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= 8'h00;
    end else if (step) begin
      cnt_reg <= cnt_reg + 8'd1;
    end
  end

  // Duty shadow: only the value present at the end of a period is taken,
  // so the last write of a period wins and a write in the eop cycle counts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_sh_reg <= 8'h00;
    end else if (eop) begin
      duty_sh_reg <= pwm_duty_cycle;
    end
  end

  // Per-pin select: disabled pins are low, enabled static pins are high,
  // enabled PWM pins follow the shared waveform.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_pin
      assign out_next[gi] = en_out[gi] & (~en_pwm[gi] | pwm);
    end
  endgenerate

  // Output flops: every pin and the period marker are registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_reg          <= 16'h0000;
      period_start_reg <= 1'b0;
    end else begin
      out_reg          <= out_next;
      period_start_reg <= period_start_next;
    end
  end

  assign out          = out_reg;
  assign period_start = period_start_reg;

endmodule

// File: doc/pwm_peripheral.md
# pwm_peripheral

Sixteen-output PWM/static driver that consumes the five control registers written over SPI (output enables, PWM enables, duty cycle) and drives the chip's 16 output pins. It sits directly downstream of the SPI register file and generates one shared ~3 kHz PWM waveform from the 10 MHz system clock. Each pin can be forced low, driven static high, or driven with the PWM waveform. Duty updates are double-buffered so a period is never truncated or glitched by a mid-period SPI write.

## Interface
- PRESCALE, 13, system clocks per PWM counter step (≥1); period = 256·PRESCALE clocks (3328 → 3004.8 Hz at 10 MHz)
- clk  in  1  10 MHz system clock
- rst_n  in  1  reset, synchronous, active-low (sampled on rising clk)
- en_reg_out_7_0  in  8  output enable, pins 7..0
- en_reg_out_15_8  in  8  output enable, pins 15..8
- en_reg_pwm_7_0  in  8  PWM select, pins 7..0
- en_reg_pwm_15_8  in  8  PWM select, pins 15..8
- pwm_duty_cycle  in  8  requested duty, 0x00 = 0 %, 0xFF = 100 %
- out  out  16  registered pin drive
- period_start  out  1  registered one-cycle pulse, aligned with the first `out` cycle of each PWM period

## Operation
- Prescaler `pre`: counts 0..PRESCALE-1, wraps to 0; `step` = (pre == PRESCALE-1). With PRESCALE = 1, `step` is constant 1.
- PWM counter `cnt` (8 bit): increments on `step`, wraps 255 → 0 (natural modulo-256).
- End of period: `eop` = step && cnt == 255. On `eop`, `duty_sh` <= pwm_duty_cycle. No other shadow load exists; writes to pwm_duty_cycle take effect only at the next period boundary.
- PWM level: `pwm` = 1 if duty_sh == 0xFF; otherwise `pwm` = (cnt < duty_sh), 8-bit unsigned compare. High time = duty_sh·PRESCALE clocks per period, except 0xFF gives a full period. 0x00 gives constant low.
- Per pin i (en_out = {en_reg_out_15_8, en_reg_out_7_0}, en_pwm likewise):
  - en_out[i] = 0 → out[i] <= 0, regardless of en_pwm[i].
  - en_out[i] = 1, en_pwm[i] = 0 → out[i] <= 1.
  - en_out[i] = 1, en_pwm[i] = 1 → out[i] <= pwm.
- period_start <= (pre == 0 && cnt == 0).
- Reset (rst_n low at a rising edge): pre = 0, cnt = 0, duty_sh = 0x00, out = 0x0000, period_start = 0. Reset mid-period aborts that period. The first period after reset runs at duty 0. The SPI value present at its end is loaded at the first `eop`.
- Enable inputs are not shadowed. Enable changes act mid-period.
- All inputs come from the clk domain. No synchronizers are used.

## Timing
- Every output is a flop. `out` in cycle t+1 reflects pre, cnt, duty_sh and the enables in cycle t. Latency from enable change to pin is 1 clock.
- First rising edge with rst_n high: pre = 0, cnt = 0. period_start is high during the following cycle. It then pulses once every 256·PRESCALE clocks.
- Duty change: a value written at any time during period N appears on the pins at the start of period N+1. If several writes occur within one period, the last value before `eop` wins. A write in the same cycle as `eop` is captured.
- PWM rising edge: at period start (out high in the period_start cycle) when duty_sh ≠ 0. Falling edge: the first `out` cycle with cnt == duty_sh.
- Simultaneous `eop` and enable change: both apply. The pin reflects the new enable and the old duty for one cycle, then the new duty.

## Test plan
- Reset/static: hold rst_n low 5 cycles with all enables at 0xFF and duty 0x80 → out = 0x0000 and period_start = 0 throughout reset. Release reset, set en_out = 0x00FF, en_pwm = 0x0000 → out = 0x00FF from the 2nd cycle after release.
- 50 % duty: en_out = en_pwm = 0xFFFF, duty = 0x80 → from the 2nd period onward, each period shows 1664 high clocks then 1664 low clocks. period_start spacing = 3328 clocks.
- Extremes: duty 0x00 → pins constantly 0 for a whole period. Duty 0xFF → pins constantly 1 for a whole period, with no single-cycle dip at the wrap.
- Double buffering: duty 0x40, then write 0xC0 at cnt ≈ 0x20 → the current period stays at 64·13 = 832 high clocks. The next period has 192·13 = 2496 high clocks.
- Mixed enables: en_out = 0xA5A5, en_pwm = 0x0F0F, duty 0x10 → pins 0, 2, 8 and 10 are PWM (208 high clocks), pins 5, 7, 13 and 15 are static high, and all other pins are 0.
- Reset mid-period: assert rst_n low at cnt = 100 with duty 0x80 active → out = 0 on the next cycle. After release, the first period is entirely low (duty_sh = 0). The second period is 50 %.
